// File: rtl/sec_blank_scheduler_pkg.sv
// Shared types and helpers for the HBLANK secondary-data scheduler.
// Steering codes, FSM state encoding and MSA burst length per lane count.
package sec_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MVID,
    GAP,
    MSA
  } sched_state_e;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_MVID  = 2'b01;
  localparam logic [1:0] ST_MSA   = 2'b10;
  localparam logic [1:0] LANE_ILL = 2'b10;

  // 36 MSA symbols spread over the enabled lanes.
  function automatic logic [5:0] msa_len(input logic [1:0] lane);
    logic [5:0] n;
    n = 6'd0;
    unique case (1'b1)
      lane == 2'b00: n = 6'd36;
      lane == 2'b01: n = 6'd18;
      lane == 2'b11: n = 6'd9;
      default:       n = 6'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sec_blank_scheduler_if.sv
// Timing-side and steering-side signals of the blank scheduler.
// master = timing generator / monitor side, slave = scheduler side.
interface sec_blank_scheduler_if;

  logic [1:0] td_lane_count;
  logic       td_vld_data;
  logic       spm_vld;
  logic       hblank_start;
  logic       vblank;
  logic [1:0] blank_steering_state0;
  logic [1:0] blank_steering_state1;
  logic [1:0] blank_steering_state2;
  logic [1:0] blank_steering_state3;
  logic       sched_busy;
  logic       msa_done;
  logic       sched_err;

  modport master (
    output td_lane_count,
    output td_vld_data,
    output spm_vld,
    output hblank_start,
    output vblank,
    input  blank_steering_state0,
    input  blank_steering_state1,
    input  blank_steering_state2,
    input  blank_steering_state3,
    input  sched_busy,
    input  msa_done,
    input  sched_err
  );

  modport slave (
    input  td_lane_count,
    input  td_vld_data,
    input  spm_vld,
    input  hblank_start,
    input  vblank,
    output blank_steering_state0,
    output blank_steering_state1,
    output blank_steering_state2,
    output blank_steering_state3,
    output sched_busy,
    output msa_done,
    output sched_err
  );

endinterface

// File: rtl/sec_blank_scheduler_fanout.sv
// Fans the active steering code out to enabled lanes; others get idle.
// Illegal lane count enables no lane at all.
module sec_lane_code_fanout
  import sec_sched_pkg::*;
(
  input  logic [1:0] code_i,
  input  logic [1:0] lane_i,
  output logic [1:0] lane0_o,
  output logic [1:0] lane1_o,
  output logic [1:0] lane2_o,
  output logic [1:0] lane3_o
);

  logic [3:0] en;

  always_comb begin
    en = 4'b0000;
    unique case (1'b1)
      lane_i == 2'b00: en = 4'b0001;
      lane_i == 2'b01: en = 4'b0011;
      lane_i == 2'b11: en = 4'b1111;
      default:         en = 4'b0000;
    endcase
  end

  assign lane0_o = en[0] ? code_i : ST_IDLE;
  assign lane1_o = en[1] ? code_i : ST_IDLE;
  assign lane2_o = en[2] ? code_i : ST_IDLE;
  assign lane3_o = en[3] ? code_i : ST_IDLE;

endmodule

// File: rtl/sec_blank_scheduler.sv
// HBLANK scheduler: one Mvid slot per line, MSA burst on first VBLANK line.
// Define MSA_REPEAT_EN to send the MSA burst on every VBLANK line.
module sec_blank_scheduler
  import sec_sched_pkg::*;
#(
  parameter int BS_DLY = 4,
  parameter int CNT_W  = 6
) (
  input logic             clk,
  input logic             rst,
  sec_blank_scheduler_if.slave bus
);

  sched_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       lane_q;
  logic [1:0]       lane_s_q;
  logic [1:0]       code_q;
  logic             msa_pend_q;
  logic             msa_pend_d;
  logic             first_q;
  logic             first_d;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             go_msa;
  logic             msa_clr;
  logic             lane_ok;

  assign lane_ok = (lane_s_q != LANE_ILL);

`ifdef MSA_REPEAT_EN
  assign go_msa  = bus.vblank & (msa_pend_q | bus.vblank);
  assign msa_clr = 1'b0;
`else
  assign go_msa  = bus.vblank & first_q & msa_pend_q;
  assign msa_clr = (state_q == GAP);
`endif

  // Set has priority over the clear on MSA entry.
  assign msa_pend_d = bus.spm_vld | (msa_pend_q & ~msa_clr);
  assign first_d    = ~bus.vblank | (first_q & ~(state_q == GAP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lane_q     <= 2'b00;
      lane_s_q   <= 2'b00;
      code_q     <= ST_IDLE;
      msa_pend_q <= 1'b0;
      first_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      msa_pend_q <= msa_pend_d;
      first_q    <= first_d;
      if (bus.td_vld_data) lane_q <= bus.td_lane_count;
      if (bus.hblank_start && state_q != IDLE) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.hblank_start) begin
            state_q  <= WAIT;
            cnt_q    <= CNT_W'(BS_DLY - 1);
            lane_s_q <= lane_q;
            busy_q   <= 1'b1;
            if (lane_q == LANE_ILL) err_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= MVID;
            code_q  <= ST_MVID;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MVID: begin
          code_q <= ST_IDLE;
          if (lane_ok && go_msa) begin
            state_q <= GAP;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        GAP: begin
          state_q <= MSA;
          code_q  <= ST_MSA;
          cnt_q   <= CNT_W'(msa_len(lane_s_q) - 6'd1);
        end
        MSA: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            code_q  <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          code_q  <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [1:0] l0, l1, l2, l3;

  sec_lane_code_fanout u_fanout (
    .code_i  (code_q),
    .lane_i  (lane_s_q),
    .lane0_o (l0),
    .lane1_o (l1),
    .lane2_o (l2),
    .lane3_o (l3)
  );

  assign bus.blank_steering_state0 = l0;
  assign bus.blank_steering_state1 = l1;
  assign bus.blank_steering_state2 = l2;
  assign bus.blank_steering_state3 = l3;
  assign bus.sched_busy            = busy_q;
  assign bus.msa_done              = done_q;
  assign bus.sched_err             = err_q;

endmodule
